// File: rtl/uart_rx_controller.sv
// Receiver sequencer: oversample divider, watchdog recovery, frame capture, Hamming(7,4) decode, nibble FIFO.
// Define UART_RX_STATS_EN to build the saturating corrected-frame counter on corr_count.
module uart_rx_controller #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WDOG_TICKS = 96
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [1:0]                    rx_state,
    input  logic                          rx_valid,
    input  logic [6:0]                    rx_data,
    output logic                          rx_tick,
    output logic                          rx_rst_n,
    output logic                          out_valid,
    output logic [3:0]                    out_data,
    output logic                          out_corrected,
    input  logic                          out_ready,
    input  logic                          err_clear,
    output logic                          overflow,
    output logic                          timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    corr_count
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int WD_W  = $clog2(WDOG_TICKS + 1);

    typedef struct packed {
        logic       corrected;
        logic [3:0] nibble;
    } entry_t;

    typedef enum logic {RUN, FLUSH} wd_state_t;

    // ---------------- oversample divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_last;

    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rx_tick  = ena & div_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   div_cnt <= '0;
        else if (ena) div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
    end

    // ---------------- watchdog FSM ----------------
    wd_state_t       wd_state, wd_state_d;
    logic [WD_W-1:0] wd_cnt, wd_cnt_d;
    logic            fl_cnt, fl_cnt_d;
    logic            timeout_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_state <= RUN;
            wd_cnt   <= '0;
            fl_cnt   <= 1'b0;
        end else begin
            wd_state <= wd_state_d;
            wd_cnt   <= wd_cnt_d;
            fl_cnt   <= fl_cnt_d;
        end
    end

    always_comb begin
        wd_state_d  = wd_state;
        wd_cnt_d    = wd_cnt;
        fl_cnt_d    = fl_cnt;
        timeout_set = 1'b0;
        case (wd_state)
            RUN: if (rx_tick) begin
                if (rx_state == 2'd0) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt == WD_W'(WDOG_TICKS - 1)) begin
                    wd_state_d  = FLUSH;
                    wd_cnt_d    = '0;
                    fl_cnt_d    = 1'b0;
                    timeout_set = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
            end
            FLUSH: begin
                wd_cnt_d = '0;
                fl_cnt_d = 1'b1;
                if (fl_cnt) wd_state_d = RUN;
            end
        endcase
    end

    // Receiver is held in reset for the whole of FLUSH and while the block itself is in reset.
    assign rx_rst_n = rst_n & (wd_state != FLUSH);

    // ---------------- capture + decode ----------------
    logic       rx_valid_q, s1_vld, frame_evt;
    logic [6:0] s1_data, fixed;
    logic [2:0] syn;
    entry_t     dec;

    assign frame_evt = rx_valid & ~rx_valid_q & (wd_state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            s1_vld     <= 1'b0;
            s1_data    <= '0;
        end else if (wd_state == FLUSH) begin
            rx_valid_q <= 1'b0;
            s1_vld     <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            s1_vld     <= frame_evt;
            if (frame_evt) s1_data <= rx_data;
        end
    end

    always_comb begin
        syn[0] = s1_data[0] ^ s1_data[2] ^ s1_data[4] ^ s1_data[6];
        syn[1] = s1_data[1] ^ s1_data[2] ^ s1_data[5] ^ s1_data[6];
        syn[2] = s1_data[3] ^ s1_data[4] ^ s1_data[5] ^ s1_data[6];
        fixed  = s1_data;
        if (syn != 3'd0) fixed[syn - 3'd1] = ~s1_data[syn - 3'd1];
        dec.corrected = (syn != 3'd0);
        dec.nibble    = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    // ---------------- nibble FIFO ----------------
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop, full, do_push;

    assign push    = s1_vld & (wd_state == RUN);
    assign pop     = out_valid & out_ready;
    assign full    = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same clock.
    assign do_push = push & (~full | pop);

    assign out_valid                 = (fifo_count != '0);
    assign {out_corrected, out_data} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- sticky flags ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            overflow <= (push & full & ~pop) | (overflow & ~err_clear);
            timeout  <= timeout_set | (timeout & ~err_clear);
        end
    end

`ifdef UART_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          corr_count <= '0;
        else if (err_clear)                                  corr_count <= '0;
        else if (do_push && dec.corrected && corr_count != 8'hFF) corr_count <= corr_count + 8'd1;
    end
`else
    assign corr_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: decode vector table plus divider, overflow, watchdog and reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_controller;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int WDOG_TICKS = 96;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [1:0] rx_state = 2'd0;
    logic       rx_valid = 1'b0;
    logic [6:0] rx_data = 7'd0;
    logic       out_ready = 1'b0, err_clear = 1'b0;
    logic       rx_tick, rx_rst_n, out_valid, out_corrected, overflow, timeout;
    logic [3:0] out_data;
    logic [2:0] fifo_count;
    logic [7:0] corr_count;

    uart_rx_controller #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .WDOG_TICKS(WDOG_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx_state(rx_state), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_tick(rx_tick), .rx_rst_n(rx_rst_n), .out_valid(out_valid),
        .out_data(out_data), .out_corrected(out_corrected), .out_ready(out_ready),
        .err_clear(err_clear), .overflow(overflow), .timeout(timeout),
        .fifo_count(fifo_count), .corr_count(corr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] code;
        logic [3:0] nib;
        logic       corr;
    } vec_t;

    vec_t vecs[10];
    int   total = 0, bad = 0, exp_corr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cc_exp(input int n);
`ifdef UART_RX_STATS_EN
        return 8'(n);
`else
        return 8'h00 & 8'(n);
`endif
    endfunction

    task automatic send(input logic [6:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        step(1);
    endtask

    initial begin
        int n, ticks;
        logic [3:0] drain_nib [4];
        logic       drain_cor [4];

        vecs[0] = '{7'h55, 4'hB, 1'b0};
        vecs[1] = '{7'h45, 4'hB, 1'b1};
        vecs[2] = '{7'h00, 4'h0, 1'b0};
        vecs[3] = '{7'h7F, 4'hF, 1'b0};
        vecs[4] = '{7'h01, 4'h0, 1'b1};
        vecs[5] = '{7'h7E, 4'hF, 1'b1};
        vecs[6] = '{7'h33, 4'h6, 1'b0};
        vecs[7] = '{7'h73, 4'h6, 1'b1};
        vecs[8] = '{7'h3B, 4'h6, 1'b1};
        vecs[9] = '{7'h56, 4'hA, 1'b1};   // double error: mis-corrected by design

        // reset state
        #12;
        check("rst_tick", rx_tick, 0);
        check("rst_rxrst", rx_rst_n, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_corr", out_corrected, 0);
        check("rst_ovf", overflow, 0);
        check("rst_tmo", timeout, 0);
        check("rst_count", fifo_count, 0);
        check("rst_cc", corr_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rel_rxrst", rx_rst_n, 1);

        // divider
        ena = 1'b1;
        n = 0;
        while (!rx_tick && n < 40) begin step(1); n++; end
        check("div_first", n, CLK_DIV - 1);
        step(1);
        check("div_pulse", rx_tick, 0);
        n = 1;
        while (!rx_tick && n < 40) begin step(1); n++; end
        check("div_period", n, CLK_DIV);
        step(3);
        ena = 1'b0;
        step(5);
        check("div_hold", rx_tick, 0);
        ena = 1'b1;
        n = 8;
        while (!rx_tick && n < 60) begin step(1); n++; end
        check("div_stretch", n, 21);

        // decode table
        for (int i = 0; i < 10; i++) begin
            rx_data  = vecs[i].code;
            rx_valid = 1'b1;
            step(1);
            check("lat1_valid", out_valid, 0);
            rx_valid = 1'b0;
            step(1);
            check("lat2_valid", out_valid, 1);
            check($sformatf("dec_data_%0d", i), out_data, vecs[i].nib);
            check($sformatf("dec_corr_%0d", i), out_corrected, vecs[i].corr);
            if (vecs[i].corr) exp_corr++;
            out_ready = 1'b1;
            step(1);
            out_ready = 1'b0;
            check("pop_empty", out_valid, 0);
        end
        check("cc_table", corr_count, cc_exp(exp_corr));

        // rx_valid held high is one frame
        rx_data  = 7'h55;
        rx_valid = 1'b1;
        step(16);
        rx_valid = 1'b0;
        step(2);
        check("held_count", fifo_count, 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("held_drain", fifo_count, 0);

        // fill, overflow, push+pop at full
        send(7'h00); send(7'h7F); send(7'h33); send(7'h55);
        check("full_count", fifo_count, 4);
        check("full_noovf", overflow, 0);
        send(7'h33);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 4'h0);
        rx_data  = 7'h45;
        rx_valid = 1'b1;
        step(1);
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        exp_corr++;
        check("pushpop_count", fifo_count, 4);
        drain_nib = '{4'hF, 4'h6, 4'hB, 4'hB};
        drain_cor = '{1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_data_%0d", i), out_data, drain_nib[i]);
            check($sformatf("drain_corr_%0d", i), out_corrected, drain_cor[i]);
            step(1);
        end
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);
        check("cc_pushpop", corr_count, cc_exp(exp_corr));
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        exp_corr  = 0;
        check("clr_ovf", overflow, 0);
        check("clr_cc", corr_count, cc_exp(exp_corr));

        // watchdog: FIFO entry must survive the flush
        send(7'h33);
        if (rx_tick) step(1);
        rx_state = 2'd1;
        ticks = 0;
        n = 0;
        while (rx_rst_n && n < WDOG_TICKS * CLK_DIV + 64) begin
            step(1);
            n++;
            if (rx_tick) ticks++;
        end
        rx_state = 2'd0;
        check("wd_fire", rx_rst_n, 0);
        check("wd_ticks", ticks, WDOG_TICKS);
        check("wd_timeout", timeout, 1);
        step(1);
        check("wd_rst2", rx_rst_n, 0);
        step(1);
        check("wd_release", rx_rst_n, 1);
        check("wd_fifo_cnt", fifo_count, 1);
        check("wd_fifo_data", out_data, 4'h6);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        check("clr_tmo", timeout, 0);

        // asynchronous reset with a frame in stage 1
        rx_data  = 7'h55;
        rx_valid = 1'b1;
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", fifo_count, 0);
        check("arst_rxrst", rx_rst_n, 0);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(3);
        check("arst_nopush", out_valid, 0);
        check("arst_cnt2", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
